// File: rtl/soc1_nios_ocimem_pkg.sv
// Shared types and constants for the Nios II OCI RAM arbiter slice.
package soc1_nios_ocimem_pkg;

    localparam int RAM_AW            = 8;
    localparam int JDO_W             = 38;
    localparam int JDO_ADDR_LSB      = 2;
    localparam int JDO_ADDR_MSB      = 9;
    localparam int JDO_DATA_LSB      = 3;
    localparam int JDO_DATA_MSB      = 34;
    localparam int RD_AFTER_LOAD_BIT = 35;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    typedef enum logic {REQ_CPU, REQ_JTAG} req_t;

    typedef enum logic [1:0] {CMD_NONE, CMD_WRITE, CMD_LOAD, CMD_READ} cmd_t;

endpackage

// File: rtl/soc1_nios_ocimem_arbiter_if.sv
// CPU debug-slave Avalon port plus the OCI RAM port, seen from the arbiter (slave) or its environment (master).
interface soc1_nios_ocimem_arbiter_if
    import soc1_nios_ocimem_pkg::*;
();

    logic [RAM_AW-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_debugaccess;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    logic [RAM_AW-1:0] ram_addr;
    logic              ram_wren;
    logic [3:0]        ram_byteen;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess, ram_rdata,
        output avs_readdata, avs_waitrequest, ram_addr, ram_wren, ram_byteen, ram_wdata
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_debugaccess, ram_rdata,
        input  avs_readdata, avs_waitrequest, ram_addr, ram_wren, ram_byteen, ram_wdata
    );

endinterface

// File: rtl/soc1_nios_ocimem_jtag_req.sv
// JTAG side of the OCI RAM arbiter: pulse decode, one-deep command latch,
// sticky overrun flag, auto-incrementing monitor address and MonDReg capture.
module soc1_nios_ocimem_jtag_req
    import soc1_nios_ocimem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              done,
    input  logic [31:0]       ram_rdata,
    output logic              req,
    output logic              req_write,
    output logic [31:0]       wdata,
    output logic [RAM_AW-1:0] jaddr,
    output logic [31:0]       MonDReg,
    output logic              jtag_overrun
);

    cmd_t       cmd;
    logic [1:0] n_pulses;
    logic       overrun_set;
    logic       unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:RD_AFTER_LOAD_BIT+1], jdo[JDO_ADDR_LSB-1:0]};

    always_comb begin
        // NOTE: default first so every path assigns cmd; otherwise a latch is inferred.
        cmd = CMD_NONE;
        if (take_action_ocimem_b)         cmd = CMD_WRITE;
        else if (take_action_ocimem_a)    cmd = CMD_LOAD;
        else if (take_no_action_ocimem_a) cmd = CMD_READ;
    end

    assign n_pulses    = {1'b0, take_action_ocimem_a} + {1'b0, take_action_ocimem_b}
                       + {1'b0, take_no_action_ocimem_a};
    // A pulse is lost if the latch is occupied or if it loses the priority decode.
    assign overrun_set = (cmd != CMD_NONE) && (req || (n_pulses > 2'd1));

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            req          <= 1'b0;
            req_write    <= 1'b0;
            wdata        <= '0;
            jaddr        <= '0;
            MonDReg      <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (done) begin
                req   <= 1'b0;
                jaddr <= jaddr + RAM_AW'(1);
                if (!req_write) MonDReg <= ram_rdata;
            end else if (!req) begin
                case (cmd)
                    CMD_WRITE: begin
                        req       <= 1'b1;
                        req_write <= 1'b1;
                        wdata     <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                    end
                    CMD_LOAD: begin
                        jaddr <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
                        if (jdo[RD_AFTER_LOAD_BIT]) begin
                            req       <= 1'b1;
                            req_write <= 1'b0;
                        end
                    end
                    CMD_READ: begin
                        req       <= 1'b1;
                        req_write <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (overrun_set) jtag_overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/soc1_nios_ocimem_arbiter.sv
// Shares the OCI RAM between the JTAG debug requester and the CPU debug slave:
// round-robin grant taken in ACCESS, three-state IDLE/ACCESS/RESP sequencing.
module soc1_nios_ocimem_arbiter
    import soc1_nios_ocimem_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [JDO_W-1:0]       jdo,
    input  logic                   take_action_ocimem_a,
    input  logic                   take_action_ocimem_b,
    input  logic                   take_no_action_ocimem_a,
    output logic [31:0]            MonDReg,
    output logic                   jtag_busy,
    output logic                   jtag_overrun,
    soc1_nios_ocimem_arbiter_if.slave bus
);

    state_t            state, state_nx;
    req_t              grant, grant_q, last_q;
    logic              jtag_req, jtag_write, jtag_done, cpu_req, cpu_resp;
    logic [31:0]       jtag_wdata;
    logic [RAM_AW-1:0] jaddr;
    logic [RAM_AW-1:0] sel_addr, addr_q;
    logic [31:0]       sel_wdata, wdata_q;
    logic [3:0]        sel_byteen, byteen_q;
    logic              sel_wren;

    soc1_nios_ocimem_jtag_req u_jtag_req (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .done                    (jtag_done),
        .ram_rdata               (bus.ram_rdata),
        .req                     (jtag_req),
        .req_write               (jtag_write),
        .wdata                   (jtag_wdata),
        .jaddr                   (jaddr),
        .MonDReg                 (MonDReg),
        .jtag_overrun            (jtag_overrun)
    );

    assign cpu_req   = bus.avs_read || bus.avs_write;
    assign jtag_busy = jtag_req;
    assign jtag_done = (state == RESP) && (grant_q == REQ_JTAG);
    assign cpu_resp  = (state == RESP) && (grant_q == REQ_CPU);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= REQ_CPU;
            last_q   <= REQ_CPU;
            addr_q   <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
        end else begin
            state    <= state_nx;
            addr_q   <= bus.ram_addr;
            wdata_q  <= bus.ram_wdata;
            byteen_q <= bus.ram_byteen;
            if (state == ACCESS) begin
                grant_q <= grant;
                last_q  <= grant;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cpu_req || jtag_req) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Grant is resolved in ACCESS, so a JTAG command latched while the CPU wins IDLE still competes.
    always_comb begin
        grant = REQ_CPU;
        if (jtag_req && (!cpu_req || last_q == REQ_CPU)) grant = REQ_JTAG;
    end

    always_comb begin
        sel_addr   = bus.avs_address;
        sel_wdata  = bus.avs_writedata;
        sel_byteen = bus.avs_byteenable;
        sel_wren   = bus.avs_write && !bus.avs_read && bus.avs_debugaccess;
        if (grant == REQ_JTAG) begin
            sel_addr   = jaddr;
            sel_wdata  = jtag_wdata;
            sel_byteen = 4'hF;
            sel_wren   = jtag_write;
        end
    end

    assign bus.ram_addr        = (state == ACCESS) ? sel_addr   : addr_q;
    assign bus.ram_wdata       = (state == ACCESS) ? sel_wdata  : wdata_q;
    assign bus.ram_byteen      = (state == ACCESS) ? sel_byteen : byteen_q;
    assign bus.ram_wren        = (state == ACCESS) && sel_wren;
    assign bus.avs_waitrequest = !cpu_resp;
    assign bus.avs_readdata    = cpu_resp ? bus.ram_rdata : '0;

endmodule

// File: tb/tb_soc1_nios_ocimem_arbiter.sv
// Randomized + directed bench for the OCI RAM arbiter: reference RAM model, expected-response queues, negedge monitor.
module tb_soc1_nios_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        jtag_busy, jtag_overrun;

    soc1_nios_ocimem_arbiter_if bus ();

    soc1_nios_ocimem_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .jtag_overrun            (jtag_overrun),
        .bus                     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        cpu_q[$];
    exp_t        jtag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic [7:0]  ref_jaddr;
    bit          ref_overrun, ref_inflight;
    logic        prev_busy = 1'b0;

    // Environment RAM: byte-enabled write, one-cycle registered read.
    always @(posedge clk) begin
        if (bus.ram_wren)
            for (int i = 0; i < 4; i++)
                if (bus.ram_byteen[i]) mem[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expected responses whenever the DUT completes a CPU or JTAG access.
    always @(negedge clk) begin
        exp_t e;
        if (bus.avs_waitrequest === 1'b0) begin
            if (cpu_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL cpu_resp_unexpected: waitrequest low with nothing outstanding");
            end else begin
                e = cpu_q.pop_front();
                if (e.is_read) check("cpu_readdata", bus.avs_readdata, e.data);
            end
        end
        if (prev_busy === 1'b1 && jtag_busy === 1'b0) begin
            if (jtag_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL jtag_done_unexpected: busy fell with nothing outstanding");
            end else begin
                e = jtag_q.pop_front();
                if (e.is_read) check("jtag_mondreg", MonDReg, e.data);
            end
        end
        prev_busy <= jtag_busy;
    end

    function automatic logic [37:0] jdo_load(input logic [7:0] a, input bit rd);
        logic [37:0] v;
        v = 38'({$urandom(), $urandom()});
        v[9:2] = a;
        v[35]  = rd;
        return v;
    endfunction

    function automatic logic [37:0] jdo_write(input logic [31:0] d);
        logic [37:0] v;
        v = 38'({$urandom(), $urandom()});
        v[34:3] = d;
        return v;
    endfunction

    // Starts a CPU access at the current cycle; strobes stay up until cpu_wait sees completion.
    task automatic cpu_start(input bit wr, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] be, input bit dbg, input bit both);
        exp_t e;
        if (wr && !both) begin
            if (dbg)
                for (int i = 0; i < 4; i++)
                    if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
            e.is_read = 1'b0;
            e.data    = '0;
        end else begin
            e.is_read = 1'b1;
            e.data    = ref_mem[a];
        end
        cpu_q.push_back(e);
        bus.avs_address     = a;
        bus.avs_read        = !wr || both;
        bus.avs_write       = wr || both;
        bus.avs_writedata   = d;
        bus.avs_byteenable  = be;
        bus.avs_debugaccess = dbg;
    endtask

    task automatic cpu_wait(input int start, input int exp_lat, input string name);
        int cyc;
        bit done;
        cyc  = start;
        done = 1'b0;
        while (!done && cyc < start + 50) begin
            @(negedge clk);
            if (bus.avs_waitrequest === 1'b0) done = 1'b1;
            else cyc++;
        end
        check(name, cyc, exp_lat);
        @(posedge clk); #1;
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
    endtask

    task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit dbg, input bit both, input string name);
        cpu_start(wr, a, d, be, dbg, both);
        cpu_wait(0, 2, name);
    endtask

    // One-cycle pulse(s) with the reference model's view of what the JTAG side must do.
    task automatic jtag_pulse(input bit a, input bit b, input bit na, input logic [37:0] d);
        exp_t e;
        int   n;
        n = int'(a) + int'(b) + int'(na);
        if (n > 0 && (ref_inflight || n > 1)) ref_overrun = 1'b1;
        if (n > 0 && !ref_inflight) begin
            if (b) begin
                ref_mem[ref_jaddr] = d[34:3];
                e.is_read = 1'b0; e.data = '0;
                jtag_q.push_back(e);
                ref_jaddr++;
                ref_inflight = 1'b1;
            end else if (a) begin
                ref_jaddr = d[9:2];
                if (d[35]) begin
                    e.is_read = 1'b1; e.data = ref_mem[ref_jaddr];
                    jtag_q.push_back(e);
                    ref_jaddr++;
                    ref_inflight = 1'b1;
                end
            end else begin
                e.is_read = 1'b1; e.data = ref_mem[ref_jaddr];
                jtag_q.push_back(e);
                ref_jaddr++;
                ref_inflight = 1'b1;
            end
        end
        jdo = d;
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = na;
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_wait(input int start, input int exp_lat, input string name);
        int cyc;
        bit done;
        cyc  = start;
        done = 1'b0;
        while (!done && cyc < start + 50) begin
            @(negedge clk);
            if (jtag_busy === 1'b0) done = 1'b1;
            else cyc++;
        end
        check(name, cyc, exp_lat);
        ref_inflight = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] orig5;
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        bus.avs_writedata = '0; bus.avs_byteenable = '0; bus.avs_debugaccess = 1'b0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = (i == 255) ? 32'hDEAD_BEEF : $urandom();
            mem[i] <= v;
            ref_mem[i] = v;
        end
        ref_jaddr = '0; ref_overrun = 1'b0; ref_inflight = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_waitrequest", 32'(bus.avs_waitrequest), 32'd1);
        check("rst_readdata",    bus.avs_readdata, 32'd0);
        check("rst_mondreg",     MonDReg, 32'd0);
        check("rst_busy",        32'(jtag_busy), 32'd0);
        check("rst_overrun",     32'(jtag_overrun), 32'd0);
        check("rst_ram_wren",    32'(bus.ram_wren), 32'd0);
        check("rst_ram_addr",    32'(bus.ram_addr), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Load 0x10, three writes, then a read proving jaddr reached 0x13.
        jtag_pulse(1'b1, 1'b0, 1'b0, jdo_load(8'h10, 1'b0));
        for (int k = 1; k <= 3; k++) begin
            jtag_pulse(1'b0, 1'b1, 1'b0, jdo_write(32'(k)));
            check("wr_busy_next_cycle", 32'(jtag_busy), 32'd1);
            jtag_wait(1, 4, "wr_latency");
        end
        jtag_pulse(1'b0, 1'b0, 1'b1, jdo_load(8'h00, 1'b0));
        jtag_wait(1, 4, "rd_at_0x13_latency");
        for (int k = 0; k < 3; k++) begin
            check("ram_0x10_block", mem[8'h10 + k], 32'(k + 1));
            cpu_op(1'b0, 8'(8'h10 + k), '0, 4'hF, 1'b0, 1'b0, "cpu_rd_latency");
        end

        // Load 0xFF with read-after-load, then a plain read after the wrap.
        jtag_pulse(1'b1, 1'b0, 1'b0, jdo_load(8'hFF, 1'b1));
        jtag_wait(1, 4, "ld_rd_latency");
        check("ld_rd_mondreg", MonDReg, 32'hDEAD_BEEF);
        jtag_pulse(1'b0, 1'b0, 1'b1, jdo_load(8'h00, 1'b0));
        jtag_wait(1, 4, "wrap_rd_latency");

        // CPU debugaccess gating and read+write treated as read.
        orig5 = ref_mem[5];
        cpu_op(1'b1, 8'h05, 32'h1234_5678, 4'b0011, 1'b0, 1'b0, "cpu_wr_nodbg_latency");
        check("nodbg_ram_unchanged", mem[5], orig5);
        cpu_op(1'b0, 8'h05, '0, 4'hF, 1'b0, 1'b0, "cpu_rd_latency");
        cpu_op(1'b1, 8'h05, 32'h1234_5678, 4'b0011, 1'b1, 1'b0, "cpu_wr_dbg_latency");
        check("dbg_ram_low_half", {16'h0, mem[5][15:0]}, 32'h0000_5678);
        check("dbg_ram_high_half", {16'h0, mem[5][31:16]}, {16'h0, orig5[31:16]});
        cpu_op(1'b0, 8'h05, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, "cpu_rdwr_latency");
        check("rdwr_no_write", {16'h0, mem[5][31:16]}, {16'h0, orig5[31:16]});

        // Tie with last grant = CPU: JTAG first, CPU completes at N+5.
        jtag_pulse(1'b1, 1'b0, 1'b0, jdo_load(8'h21, 1'b0));
        cpu_start(1'b0, 8'h20, '0, 4'hF, 1'b0, 1'b0);
        jtag_pulse(1'b0, 1'b0, 1'b1, jdo_load(8'h00, 1'b0));
        cpu_wait(1, 5, "tieA_cpu_latency");
        check("tieA_jtag_idle", 32'(jtag_busy), 32'd0);
        ref_inflight = 1'b0;

        // JTAG alone, then a tie with last grant = JTAG: CPU first, JTAG done at N+6.
        jtag_pulse(1'b0, 1'b0, 1'b1, jdo_load(8'h00, 1'b0));
        jtag_wait(1, 4, "solo_jtag_latency");
        cpu_start(1'b0, 8'h30, '0, 4'hF, 1'b0, 1'b0);
        jtag_pulse(1'b0, 1'b0, 1'b1, jdo_load(8'h00, 1'b0));
        cpu_wait(1, 2, "tieB_cpu_latency");
        jtag_wait(3, 6, "tieB_jtag_latency");

        // Overrun: pulse while busy, pulse in RESP, and simultaneous write+read.
        check("pre_overrun_flag", 32'(jtag_overrun), 32'(ref_overrun));
        jtag_pulse(1'b1, 1'b0, 1'b0, jdo_load(8'h60, 1'b0));
        jtag_pulse(1'b0, 1'b1, 1'b0, jdo_write(32'hAAAA_0001));
        check("ovr_busy", 32'(jtag_busy), 32'd1);
        jtag_pulse(1'b0, 1'b1, 1'b0, jdo_write(32'hBBBB_0002));
        jtag_wait(2, 4, "ovr_first_wr_latency");
        check("ovr_flag_set", 32'(jtag_overrun), 32'(ref_overrun));
        jtag_pulse(1'b0, 1'b1, 1'b1, jdo_write(32'hCCCC_0003));
        jtag_wait(1, 4, "ovr_wr_rd_latency");
        jtag_pulse(1'b0, 1'b0, 1'b1, jdo_load(8'h00, 1'b0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        jtag_pulse(1'b0, 1'b1, 1'b0, jdo_write(32'hDDDD_0004));
        jtag_wait(4, 4, "resp_pulse_latency");
        check("ovr_flag_sticky", 32'(jtag_overrun), 32'(ref_overrun));
        for (int k = 0; k < 4; k++)
            cpu_op(1'b0, 8'(8'h60 + k), '0, 4'hF, 1'b0, 1'b0, "cpu_rd_latency");

        // Reset in the ACCESS cycle of a CPU write; held strobe is re-served.
        cpu_start(1'b1, 8'h40, 32'h5A5A_A5A5, 4'hF, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("rst_mid_access_wren", 32'(bus.ram_wren), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        ref_overrun = 1'b0;
        ref_jaddr   = '0;
        check("rst_mid_wren",        32'(bus.ram_wren), 32'd0);
        check("rst_mid_waitrequest", 32'(bus.avs_waitrequest), 32'd1);
        check("rst_mid_readdata",    bus.avs_readdata, 32'd0);
        check("rst_mid_mondreg",     MonDReg, 32'd0);
        check("rst_mid_overrun",     32'(jtag_overrun), 32'd0);
        check("rst_mid_ram_addr",    32'(bus.ram_addr), 32'd0);
        reset = 1'b0;
        cpu_wait(2, 4, "rst_reserve_latency");
        jtag_pulse(1'b0, 1'b0, 1'b1, jdo_load(8'h00, 1'b0));
        jtag_wait(1, 4, "post_rst_rd_latency");

        // Randomized sequential traffic against the reference model.
        for (int k = 0; k < 60; k++) begin
            logic [7:0] a;
            bit         rd;
            a = 8'($urandom());
            case ($urandom_range(0, 5))
                0: cpu_op(1'b0, a, '0, 4'hF, 1'($urandom()), 1'b0, "rnd_cpu_rd_latency");
                1: cpu_op(1'b1, a, $urandom(), 4'($urandom()), 1'($urandom()), 1'b0, "rnd_cpu_wr_latency");
                2: begin
                    rd = 1'($urandom());
                    jtag_pulse(1'b1, 1'b0, 1'b0, jdo_load(a, rd));
                    if (rd) jtag_wait(1, 4, "rnd_ld_rd_latency");
                end
                3: begin
                    jtag_pulse(1'b0, 1'b1, 1'b0, jdo_write($urandom()));
                    jtag_wait(1, 4, "rnd_jtag_wr_latency");
                end
                default: begin
                    jtag_pulse(1'b0, 1'b0, 1'b1, jdo_load(8'h00, 1'b0));
                    jtag_wait(1, 4, "rnd_jtag_rd_latency");
                end
            endcase
        end
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) check("final_ram_word", mem[i], ref_mem[i]);

        repeat (3) @(posedge clk); #1;
        check("final_overrun", 32'(jtag_overrun), 32'(ref_overrun));
        check("cpu_q_drained",  32'(cpu_q.size()), 32'd0);
        check("jtag_q_drained", 32'(jtag_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
